// File: rtl/time_counter.sv
// Time-of-day engine: 1 Hz prescaler, seconds/minutes/hours counters and a
// mode/inc/dec set-time FSM. Define HOUR12_EN for 12-hour display with a PM flag.
module time_counter #(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [1:0] set_mode,
    output logic       tick_1hz,
    output logic       pm
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

`ifdef HOUR12_EN
    localparam bit H12 = 1'b1;
`else
    localparam bit H12 = 1'b0;
`endif

    localparam logic [4:0] HOUR_RST = H12 ? 5'd12 : 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    mode_t         state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [5:0]    sec_s, min_s;
    logic [4:0]    hr_s;
    logic          pm_s, tick_s;

    function automatic logic [4:0] hr_up(input logic [4:0] h);
        if (H12) hr_up = (h == 5'd12) ? 5'd1 : h + 5'd1;
        else     hr_up = (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hr_dn(input logic [4:0] h);
        if (H12) hr_dn = (h == 5'd1) ? 5'd12 : h - 5'd1;
        else     hr_dn = (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    assign set_mode = state_r;

    // State, prescaler and time registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= RUN;
            presc_r  <= '0;
            seconds  <= 6'd0;
            minutes  <= 6'd0;
            hours    <= HOUR_RST;
            pm       <= 1'b0;
            tick_1hz <= 1'b0;
        end else begin
            state_r  <= state_s;
            presc_r  <= presc_s;
            seconds  <= sec_s;
            minutes  <= min_s;
            hours    <= hr_s;
            pm       <= pm_s;
            tick_1hz <= tick_s;
        end
    end

    // Next-state: mode_pulse wins, then RUN counting, then set-mode adjustment
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        sec_s   = seconds;
        min_s   = minutes;
        hr_s    = hours;
        pm_s    = pm;
        tick_s  = 1'b0;
        if (mode_pulse) begin
            presc_s = '0;
            case (state_r)
                RUN:     state_s = SET_HR;
                SET_HR:  state_s = SET_MIN;
                SET_MIN: begin
                    state_s = RUN;
                    sec_s   = 6'd0;
                end
                default: state_s = RUN;
            endcase
        end else if (state_r == RUN) begin
            if (presc_r == PRESC_MAX) begin
                presc_s = '0;
                tick_s  = 1'b1;
                if (seconds == 6'd59) begin
                    sec_s = 6'd0;
                    if (minutes == 6'd59) begin
                        min_s = 6'd0;
                        hr_s  = hr_up(hours);
                        pm_s  = (H12 && hours == 5'd11) ? ~pm : pm;
                    end else begin
                        min_s = minutes + 6'd1;
                    end
                end else begin
                    sec_s = seconds + 6'd1;
                end
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = '0;
            // Opposing inc and dec cancel out
            if (inc_pulse != dec_pulse) begin
                case (state_r)
                    SET_HR: begin
                        if (inc_pulse) begin
                            hr_s = hr_up(hours);
                            pm_s = (H12 && hours == 5'd11) ? ~pm : pm;
                        end else begin
                            hr_s = hr_dn(hours);
                            pm_s = (H12 && hours == 5'd12) ? ~pm : pm;
                        end
                    end
                    SET_MIN: begin
                        if (inc_pulse) min_s = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                        else           min_s = (minutes == 6'd0) ? 6'd59 : minutes - 6'd1;
                    end
                    default: state_s = RUN;
                endcase
            end else begin
                state_s = (state_r == SET_HR || state_r == SET_MIN) ? state_r : RUN;
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Randomized and directed bench for time_counter; the reference keeps time as
// a single second-of-day count plus a mode number and a prescaler phase.
module tb_time_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_pulse, inc_pulse, dec_pulse;
    logic [5:0] seconds, minutes;
    logic [4:0] hours;
    logic [1:0] set_mode;
    logic       tick_1hz, pm;

    int n_checks = 0;
    int n_fail   = 0;

    int m_tsec, m_mode, m_cnt;
    bit m_tick;

    time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset),
        .mode_pulse(mode_pulse), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .set_mode(set_mode), .tick_1hz(tick_1hz), .pm(pm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tsec = 0; m_mode = 0; m_cnt = 0; m_tick = 1'b0;
    endtask

    task automatic model_step(input bit mp, input bit ip, input bit dp);
        int h, m, s;
        m_tick = 1'b0;
        if (mp) begin
            m_cnt = 0;
            if (m_mode == 0)      m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else begin
                m_mode = 0;
                m_tsec = m_tsec - (m_tsec % 60);
            end
        end else if (m_mode == 0) begin
            if (m_cnt == CLK_HZ - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                m_tsec = (m_tsec + 1) % 86400;
            end else begin
                m_cnt++;
            end
        end else if (ip != dp) begin
            h = m_tsec / 3600; m = (m_tsec / 60) % 60; s = m_tsec % 60;
            if (m_mode == 1) h = (h + (ip ? 1 : 23)) % 24;
            else             m = (m + (ip ? 1 : 59)) % 60;
            m_tsec = h * 3600 + m * 60 + s;
        end
    endtask

    task automatic check_all(input string tag);
        int h24, exp_h, exp_pm;
        h24 = m_tsec / 3600;
`ifdef HOUR12_EN
        exp_h  = (h24 % 12 == 0) ? 12 : h24 % 12;
        exp_pm = (h24 >= 12) ? 1 : 0;
`else
        exp_h  = h24;
        exp_pm = 0;
`endif
        check_eq({tag, "_sec"},  int'(seconds),  m_tsec % 60);
        check_eq({tag, "_min"},  int'(minutes),  (m_tsec / 60) % 60);
        check_eq({tag, "_hr"},   int'(hours),    exp_h);
        check_eq({tag, "_pm"},   int'(pm),       exp_pm);
        check_eq({tag, "_mode"}, int'(set_mode), m_mode);
        check_eq({tag, "_tick"}, int'(tick_1hz), int'(m_tick));
    endtask

    task automatic step(input string tag, input bit mp, input bit ip, input bit dp);
        mode_pulse = mp; inc_pulse = ip; dec_pulse = dp;
        @(posedge clk);
        model_step(mp, ip, dp);
        #1;
        mode_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        mode_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
`ifdef HOUR12_EN
        check_eq("h12_rst_hr", int'(hours), 12);
        check_eq("h12_rst_pm", int'(pm), 0);
`endif
        reset = 1'b0;

        // First second and first minute
        run("t1", 3);
        step("t1_tick", 1'b0, 1'b0, 1'b0);
        check_eq("t1_tick4", int'(tick_1hz), 1);
        run("t1", 236);
        check_eq("t1_min", int'(minutes), 1);
        check_eq("t1_sec0", int'(seconds), 0);

        // Preload 23:59 (hour 0 -> 23 by dec, minute 1 -> 59), then run to 58 s
        step("t2", 1'b1, 1'b0, 1'b0);
        step("t2", 1'b0, 1'b0, 1'b1);
        step("t2", 1'b1, 1'b0, 1'b0);
        step("t2", 1'b0, 1'b0, 1'b1);
        step("t2", 1'b0, 1'b0, 1'b1);
        step("t2", 1'b1, 1'b0, 1'b0);
        run("t2", 58 * CLK_HZ);
        run("t2_roll", 2 * CLK_HZ);
`ifndef HOUR12_EN
        check_eq("t2_roll_hr", int'(hours), 0);
        check_eq("t2_roll_min", int'(minutes), 0);
`endif

        // Set hours up by three, minutes down by one, return to RUN
        step("t3", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t3_inc", 1'b0, 1'b1, 1'b0);
        step("t3", 1'b1, 1'b0, 1'b0);
        step("t3_dec", 1'b0, 1'b0, 1'b1);
        check_eq("t3_min59", int'(minutes), 59);
        step("t3_run", 1'b1, 1'b0, 1'b0);
        run("t3_wait", CLK_HZ);

        // Simultaneous events
        step("t4", 1'b1, 1'b0, 1'b0);
        step("t4_both", 1'b0, 1'b1, 1'b1);
        step("t4_mode_inc", 1'b1, 1'b1, 1'b0);
        step("t4", 1'b1, 1'b0, 1'b0);
        step("t4_run_inc", 1'b0, 1'b1, 1'b0);
        step("t4_run_dec", 1'b0, 1'b0, 1'b1);

        // Reach 05:17:33 at prescaler phase 2, then reset asynchronously
        step("t5", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("t5", 1'b0, 1'b1, 1'b0);
        step("t5", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) step("t5", 1'b0, 1'b1, 1'b0);
        step("t5", 1'b1, 1'b0, 1'b0);
        run("t5", 33 * CLK_HZ + 2);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("t5_async");
        @(posedge clk);
        #1 check_all("t5_hold");
        reset = 1'b0;
        run("t5_rel", CLK_HZ);

        // Randomized pulses against the reference
        for (int i = 0; i < 4000; i++) begin
            step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
